// File: rtl/graphics_cmd_master.sv
// Bus initiator for the graphics controller: loads the six draw registers with
// 68k-style write cycles, then polls the status register until drawing ends.
module graphics_cmd_master #(
   parameter int HOLD_CYCLES = 2,
   parameter int POLL_LIMIT  = 1024
) (
   input  logic        Clk,
   input  logic        Reset_L,
   input  logic        Req_Valid,
   output logic        Req_Ready,
   input  logic [9:0]  Req_X1,
   input  logic [9:0]  Req_Y1,
   input  logic [9:0]  Req_X2,
   input  logic [9:0]  Req_Y2,
   input  logic [7:0]  Req_Colour,
   input  logic [15:0] Req_Cmd,
   output logic [15:0] AddressOut,
   output logic [15:0] DataOutToCtrl,
   input  logic [15:0] DataInFromCtrl,
   output logic        GraphicsCS_L,
   output logic        AS_L,
   output logic        UDS_L,
   output logic        LDS_L,
   output logic        RW,
   output logic        Done,
   output logic        Timeout
);

   localparam int PW_RAW = $clog2(POLL_LIMIT + 1);
   localparam int PW     = (PW_RAW < 11) ? 11 : PW_RAW;
   localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_W_SETUP   = 4'd1,
      S_W_STROBE  = 4'd2,
      S_W_RELEASE = 4'd3,
      S_P_SETUP   = 4'd4,
      S_P_STROBE  = 4'd5,
      S_P_RELEASE = 4'd6,
      S_DONE      = 4'd7,
      S_TOUT      = 4'd8
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [PW-1:0]   polls_q, polls_d;
   logic            busy_q, busy_d;
   logic            accept_s;
   logic [9:0]      x1_q, y1_q, x2_q, y2_q;
   logic [7:0]      colour_q;
   logic [15:0]     cmd_q;
   logic [15:0]     addr_q, addr_d, data_q, data_d;
   logic            cs_q, cs_d, strb_q, strb_d, rw_q, rw_d;
   logic            ready_q, ready_d, done_q, done_d, tout_q, tout_d;

   // Register address for write slot idx; command goes last because it starts the draw.
   function automatic logic [15:0] wr_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    wr_addr = 16'h0002;
         3'd1:    wr_addr = 16'h0004;
         3'd2:    wr_addr = 16'h0006;
         3'd3:    wr_addr = 16'h0008;
         3'd4:    wr_addr = 16'h000E;
         default: wr_addr = 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] wr_data(input logic [2:0] idx);
      case (idx)
         3'd0:    wr_data = {6'd0, x1_q};
         3'd1:    wr_data = {6'd0, y1_q};
         3'd2:    wr_data = {6'd0, x2_q};
         3'd3:    wr_data = {6'd0, y2_q};
         3'd4:    wr_data = {8'd0, colour_q};
         default: wr_data = cmd_q;
      endcase
   endfunction

   // Next-state logic; bus outputs are decoded from the next state so they are registered.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      hold_d   = hold_q;
      polls_d  = polls_q;
      busy_d   = busy_q;
      addr_d   = addr_q;
      data_d   = data_q;
      accept_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Req_Valid) begin
               accept_s = 1'b1;
               state_d  = S_W_SETUP;
               idx_d    = 3'd0;
               polls_d  = '0;
               addr_d   = 16'h0002;
               data_d   = {6'd0, Req_X1};
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_W_SETUP: begin
            hold_d  = '0;
            state_d = S_W_STROBE;
         end
         S_W_STROBE: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_W_RELEASE;
            end else begin
               hold_d  = hold_q + {{(HW-1){1'b0}}, 1'b1};
            end
         end
         S_W_RELEASE: begin
            if (idx_q == 3'd5) begin
               state_d = S_P_SETUP;
               addr_d  = 16'h0000;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_W_SETUP;
               addr_d  = wr_addr(idx_q + 3'd1);
               data_d  = wr_data(idx_q + 3'd1);
            end
         end
         S_P_SETUP: begin
            hold_d  = '0;
            state_d = S_P_STROBE;
         end
         S_P_STROBE: begin
            if (hold_q == HOLD_LAST) begin
               busy_d  = DataInFromCtrl[0];
               polls_d = polls_q + {{(PW-1){1'b0}}, 1'b1};
               state_d = S_P_RELEASE;
            end else begin
               hold_d  = hold_q + {{(HW-1){1'b0}}, 1'b1};
            end
         end
         S_P_RELEASE: begin
            // A not-busy reading wins even when this was the last permitted poll.
            if (!busy_q) begin
               state_d = S_DONE;
            end else if (polls_q >= POLL_MAX) begin
               state_d = S_TOUT;
            end else begin
               state_d = S_P_SETUP;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_TOUT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      cs_d    = !((state_d == S_W_SETUP) || (state_d == S_W_STROBE) ||
                  (state_d == S_P_SETUP) || (state_d == S_P_STROBE));
      strb_d  = !((state_d == S_W_STROBE) || (state_d == S_P_STROBE));
      rw_d    = !((state_d == S_W_SETUP) || (state_d == S_W_STROBE) ||
                  (state_d == S_W_RELEASE));
      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
      tout_d  = (state_d == S_TOUT);
   end

   // State, counters and registered bus outputs.
   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         hold_q  <= '0;
         polls_q <= '0;
         busy_q  <= 1'b0;
         addr_q  <= 16'h0000;
         data_q  <= 16'h0000;
         cs_q    <= 1'b1;
         strb_q  <= 1'b1;
         rw_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         polls_q <= polls_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cs_q    <= cs_d;
         strb_q  <= strb_d;
         rw_q    <= rw_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         tout_q  <= tout_d;
      end
   end

   // Request capture on acceptance.
   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         x1_q     <= 10'd0;
         y1_q     <= 10'd0;
         x2_q     <= 10'd0;
         y2_q     <= 10'd0;
         colour_q <= 8'd0;
         cmd_q    <= 16'd0;
      end else if (accept_s) begin
         x1_q     <= Req_X1;
         y1_q     <= Req_Y1;
         x2_q     <= Req_X2;
         y2_q     <= Req_Y2;
         colour_q <= Req_Colour;
         cmd_q    <= Req_Cmd;
      end
   end

   assign Req_Ready     = ready_q;
   assign AddressOut    = addr_q;
   assign DataOutToCtrl = data_q;
   assign GraphicsCS_L  = cs_q;
   assign AS_L          = strb_q;
   assign UDS_L         = strb_q;
   assign LDS_L         = strb_q;
   assign RW            = rw_q;
   assign Done          = done_q;
   assign Timeout       = tout_q;

endmodule
